// File: rtl/mode_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mode_arbiter_ctrl
// Three-source arbiter (fixed / round-robin / locked / off) onto one
// registered valid/ready channel with sticky timeout and range errors.
// Rev    : 1.0  initial release
// ============================================================================
module mode_arbiter_ctrl #(
  parameter int                DATA_W      = 8,
  parameter int                TIMEOUT_CYC = 16,
  parameter logic [DATA_W-1:0] RANGE_MAX   = 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [3:0]        config_bits,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              req_c,
  input  logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_in_b,
  input  logic [DATA_W-1:0] data_in_c,
  input  logic              data_ready,
  input  logic              err_clr,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              gnt_c,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        src_id,
  output logic              busy,
  output logic              error_flag,
  output logic              range_err
);

  localparam int               CNT_W      = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_gnt, w_gnt_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [1:0]          r_src, w_src_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_err, w_err_nxt;
  logic                r_rerr, w_rerr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [1:0]          r_ptr, w_ptr_nxt;

  logic [2:0]          w_req;
  logic [1:0]          w_rr0, w_rr1, w_rr2;
  logic                w_win_vld;
  logic [1:0]          w_win;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_unused;

  assign w_unused = config_bits[3];

  // Round-robin search order starts one past the last winner.
  always_comb begin
    w_req     = {req_c, req_b, req_a};
    w_rr0     = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_rr1     = (w_rr0 == 2'd2) ? 2'd0 : w_rr0 + 2'd1;
    w_rr2     = (w_rr1 == 2'd2) ? 2'd0 : w_rr1 + 2'd1;
    w_win_vld = 1'b0;
    w_win     = 2'd0;
    case (mode)
      2'b00: begin
        if (req_a) begin
          w_win_vld = 1'b1; w_win = 2'd0;
        end else if (req_b) begin
          w_win_vld = 1'b1; w_win = 2'd1;
        end else if (req_c) begin
          w_win_vld = 1'b1; w_win = 2'd2;
        end
      end
      2'b01: begin
        if (w_req[w_rr0]) begin
          w_win_vld = 1'b1; w_win = w_rr0;
        end else if (w_req[w_rr1]) begin
          w_win_vld = 1'b1; w_win = w_rr1;
        end else if (w_req[w_rr2]) begin
          w_win_vld = 1'b1; w_win = w_rr2;
        end
      end
      2'b10: begin
        if ((config_bits[1:0] != 2'd3) && w_req[config_bits[1:0]]) begin
          w_win_vld = 1'b1; w_win = config_bits[1:0];
        end
      end
      default: ;
    endcase
    case (w_win)
      2'd1:    w_win_data = data_in_b;
      2'd2:    w_win_data = data_in_c;
      default: w_win_data = data_in_a;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = 3'b000;
    w_data_nxt  = r_data;
    w_src_nxt   = r_src;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_err_nxt   = r_err & ~err_clr;
    w_rerr_nxt  = r_rerr & ~err_clr;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_gnt_nxt   = 3'b001 << w_win;
          w_data_nxt  = w_win_data;
          w_src_nxt   = w_win;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
          if (mode == 2'b01) w_ptr_nxt = w_win;
          if (config_bits[2] && (w_win_data > RANGE_MAX)) w_rerr_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (data_ready) begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_CNT_LAST) begin
          // Downstream stalled too long: drop the transfer and flag it.
          w_err_nxt   = 1'b1;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 3'b000;
      r_data  <= '0;
      r_src   <= 2'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rerr  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= 2'd2;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_data  <= w_data_nxt;
      r_src   <= w_src_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_rerr  <= w_rerr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt_a      = r_gnt[0];
  assign gnt_b      = r_gnt[1];
  assign gnt_c      = r_gnt[2];
  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign src_id     = r_src;
  assign busy       = r_busy;
  assign error_flag = r_err;
  assign range_err  = r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_mode_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mode_arbiter_ctrl
// Directed + random bench for mode_arbiter_ctrl with a transfer scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mode_arbiter_ctrl;

  localparam int TMO  = 16;
  localparam int RMAX = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] config_bits = 4'd0;
  logic       req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic [7:0] data_in_a = 8'd0, data_in_b = 8'd0, data_in_c = 8'd0;
  logic       data_ready = 1'b0, err_clr = 1'b0;
  logic       gnt_a, gnt_b, gnt_c, valid_out, busy, error_flag, range_err;
  logic [7:0] data_out;
  logic [1:0] src_id;

  int total = 0;
  int bad   = 0;

  mode_arbiter_ctrl #(.DATA_W(8), .TIMEOUT_CYC(TMO), .RANGE_MAX(8'h80)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .config_bits(config_bits),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .data_in_c(data_in_c),
    .data_ready(data_ready), .err_clr(err_clr),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
    .data_out(data_out), .valid_out(valid_out), .src_id(src_id),
    .busy(busy), .error_flag(error_flag), .range_err(range_err)
  );

  always #5 clk = ~clk;

  // Reference model state: whole-transfer view, not a copy of the RTL FSM.
  bit   m_live = 0;
  bit   m_xfer = 0;
  int   m_stall = 0;
  int   m_ptr = 2;
  logic [2:0] m_gnt = '0;
  logic [7:0] m_data = '0;
  logic [1:0] m_src = '0;
  bit   m_valid = 0, m_err = 0, m_rerr = 0;
  int   exp_src[$];
  int   exp_data[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] md, input logic [3:0] cf,
                              input logic [2:0] rq, input int ptr);
    int res;
    int idx;
    res = -1;
    case (md)
      2'd0: for (int k = 0; k < 3; k++) if (res < 0 && rq[k]) res = k;
      2'd1: for (int k = 1; k <= 3; k++) begin
              idx = (ptr + k) % 3;
              if (res < 0 && rq[idx]) res = idx;
            end
      2'd2: if (cf[1:0] != 2'd3 && rq[cf[1:0]]) res = int'(cf[1:0]);
      default: ;
    endcase
    return res;
  endfunction

  task automatic model_step();
    int   w;
    int   d[3];
    bit   e, r;
    d[0] = int'(data_in_a); d[1] = int'(data_in_b); d[2] = int'(data_in_c);
    if (!rst_n) begin
      m_live = 1; m_xfer = 0; m_stall = 0; m_ptr = 2; m_gnt = '0;
      m_data = '0; m_src = '0; m_valid = 0; m_err = 0; m_rerr = 0;
      exp_src.delete(); exp_data.delete();
      return;
    end
    e = m_err && !err_clr;
    r = m_rerr && !err_clr;
    m_gnt = '0;
    if (!m_xfer) begin
      w = pick(mode, config_bits, {req_c, req_b, req_a}, m_ptr);
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_data   = d[w][7:0];
        m_src    = w[1:0];
        m_valid  = 1; m_xfer = 1; m_stall = 0;
        if (mode == 2'd1) m_ptr = w;
        if (config_bits[2] && d[w] > RMAX) r = 1;
        exp_src.push_back(w);
        exp_data.push_back(d[w]);
      end
    end else if (data_ready) begin
      m_valid = 0; m_xfer = 0;
    end else begin
      m_stall++;
      if (m_stall == TMO) begin
        m_valid = 0; m_xfer = 0; e = 1;
      end
    end
    m_err = e; m_rerr = r;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-level comparison against the model.
  initial forever begin
    @(posedge clk); #1;
    if (m_live) begin
      cmp("gnt",        {29'd0, gnt_c, gnt_b, gnt_a}, {29'd0, m_gnt});
      cmp("data_out",   {24'd0, data_out},  {24'd0, m_data});
      cmp("valid_out",  {31'd0, valid_out}, {31'd0, m_valid});
      cmp("src_id",     {30'd0, src_id},    {30'd0, m_src});
      cmp("busy",       {31'd0, busy},      {31'd0, m_xfer});
      cmp("error_flag", {31'd0, error_flag}, {31'd0, m_err});
      cmp("range_err",  {31'd0, range_err}, {31'd0, m_rerr});
    end
  end

  // Scoreboard monitor: every DUT grant consumes one predicted transfer.
  initial forever begin
    int s, dd;
    @(posedge clk); #1;
    if (m_live && (gnt_a || gnt_b || gnt_c)) begin
      if (exp_src.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected @%0t: got grant src=%0d expected none", $time, src_id);
      end else begin
        s  = exp_src.pop_front();
        dd = exp_data.pop_front();
        cmp("sb_src",  {30'd0, src_id}, s);
        cmp("sb_data", {24'd0, data_out}, dd);
        cmp("sb_valid", {31'd0, valid_out}, 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int pct;
    tick(2);
    cmp("reset_outs", {19'd0, gnt_a, gnt_b, gnt_c, data_out, valid_out, src_id, busy, error_flag, range_err}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // 1: fixed priority
    mode = 2'd0; data_ready = 1'b1;
    data_in_a = 8'h11; data_in_b = 8'h22; data_in_c = 8'h33;
    req_a = 1; req_b = 1; req_c = 1;
    tick(1);
    cmp("t1_gnt_a", {31'd0, gnt_a}, 32'd1);
    cmp("t1_data_a", {24'd0, data_out}, 32'h11);
    cmp("t1_src_a", {30'd0, src_id}, 32'd0);
    req_a = 0;
    tick(2);
    cmp("t1_gnt_b", {31'd0, gnt_b}, 32'd1);
    cmp("t1_data_b", {24'd0, data_out}, 32'h22);
    req_b = 0; req_c = 0;
    tick(2);

    // 2: round-robin from reset pointer
    mode = 2'd1; req_a = 1; req_b = 1; req_c = 1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      cmp("t2_rr_src", {30'd0, src_id}, i % 3);
      cmp("t2_rr_valid", {31'd0, valid_out}, 32'd1);
      tick(1);
    end
    req_a = 0; req_b = 0; req_c = 0;
    tick(2);

    // 3: locked and disabled
    mode = 2'd2; config_bits = 4'b0010; req_a = 1; req_b = 1;
    tick(4);
    cmp("t3_lock_none", {31'd0, busy}, 32'd0);
    req_c = 1; data_in_c = 8'h5A;
    tick(1);
    cmp("t3_gnt_c", {31'd0, gnt_c}, 32'd1);
    cmp("t3_data_c", {24'd0, data_out}, 32'h5A);
    config_bits = 4'b0011;
    tick(4);
    cmp("t3_sel3", {31'd0, busy}, 32'd0);
    mode = 2'd3;
    tick(3);
    cmp("t3_off", {31'd0, busy}, 32'd0);
    req_a = 0; req_b = 0; req_c = 0;
    config_bits = 4'd0;
    tick(1);

    // 4: timeout
    mode = 2'd0; data_ready = 0; req_a = 1; data_in_a = 8'h10;
    tick(1);
    req_a = 0;
    cnt = valid_out ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (valid_out) cnt++;
      else break;
    end
    cmp("t4_valid_cycles", cnt, TMO);
    cmp("t4_err_set", {31'd0, error_flag}, 32'd1);
    cmp("t4_busy_low", {31'd0, busy}, 32'd0);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    cmp("t4_err_clr", {31'd0, error_flag}, 32'd0);

    // 5: range check
    data_ready = 1; config_bits = 4'b0100;
    data_in_a = 8'h81; req_a = 1;
    tick(1);
    req_a = 0;
    cmp("t5_range_81", {31'd0, range_err}, 32'd1);
    tick(1);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    cmp("t5_range_clr", {31'd0, range_err}, 32'd0);
    data_in_a = 8'h80; req_a = 1;
    tick(1);
    req_a = 0;
    cmp("t5_range_80", {31'd0, range_err}, 32'd0);
    tick(1);
    data_in_a = 8'h81; req_a = 1; err_clr = 1;
    tick(1);
    req_a = 0; err_clr = 0;
    cmp("t5_set_wins", {31'd0, range_err}, 32'd1);
    tick(1);
    config_bits = 4'd0;

    // 6: reset mid-transfer
    data_ready = 0; data_in_a = 8'h44; req_a = 1;
    tick(1);
    req_a = 0; mode = 2'd3;
    tick(1);
    rst_n = 0;
    tick(1);
    cmp("t6_reset_outs", {19'd0, gnt_a, gnt_b, gnt_c, data_out, valid_out, src_id, busy, error_flag, range_err}, 32'd0);
    rst_n = 1; mode = 2'd1; data_ready = 1;
    req_a = 1; req_b = 1; req_c = 1;
    tick(1);
    cmp("t6_rr_first_a", {31'd0, gnt_a}, 32'd1);
    req_a = 0; req_b = 0; req_c = 0;
    tick(2);

    // Random phase, with varying downstream back-pressure.
    for (int blk = 0; blk < 4; blk++) begin
      pct = (blk == 0) ? 70 : (blk == 1) ? 8 : (blk == 2) ? 95 : 40;
      for (int i = 0; i < 150; i++) begin
        rst_n       = ($urandom_range(0, 99) != 0);
        if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) config_bits = 4'($urandom_range(0, 15));
        req_a       = ($urandom_range(0, 9) < 6);
        req_b       = ($urandom_range(0, 9) < 6);
        req_c       = ($urandom_range(0, 9) < 6);
        data_in_a   = 8'($urandom);
        data_in_b   = 8'($urandom);
        data_in_c   = 8'($urandom);
        data_ready  = ($urandom_range(0, 99) < pct);
        err_clr     = ($urandom_range(0, 19) == 0);
        tick(1);
      end
    end

    rst_n = 1; req_a = 0; req_b = 0; req_c = 0; err_clr = 0; data_ready = 1;
    tick(3);
    cmp("sb_left", exp_src.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
